// File: rtl/horner_poly_solver.sv
// Signed polynomial evaluator using Horner's method, one multiply-accumulate per clock.
// Coefficients live in a small register file; results use a start/ready/valid handshake.
module horner_poly_solver #(
    parameter int XW     = 8,
    parameter int DW     = 16,
    parameter int DEGREE = 2,
    parameter int AW     = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_data,
    output logic [DW-1:0] result,
    output logic          overflow,
    output logic          ready,
    output logic          valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int FW = DW + XW + 1;
    localparam logic [AW-1:0] LAST  = AW'(DEGREE);
    localparam logic [AW-1:0] FIRST = AW'(DEGREE - 1);

    logic [1:0]              state;
    logic [AW-1:0]           cnt;
    logic signed [XW-1:0]    x_reg;
    logic signed [DW-1:0]    acc;
    logic signed [DW-1:0]    coef [2**AW];
    logic signed [FW-1:0]    full;
    logic                    step_ovf;

    // Entries above DEGREE are never written and stay zero.
    always_comb begin
        full     = FW'(acc) * FW'(x_reg) + FW'(coef[cnt]);
        step_ovf = full[FW-1:DW-1] != {(XW+2){full[DW-1]}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            x_reg    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
            // NOTE: the coefficient file is a handful of flops, not a RAM, so clearing it in reset is cheap and makes post-reset results defined.
            for (int i = 0; i < 2**AW; i++) coef[i] <= '0;
        end else begin
            if (coef_we && state != RUN && coef_addr <= LAST)
                coef[coef_addr] <= coef_data;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // NOTE: non-blocking reads give the pre-edge c[DEGREE], so a same-edge write does not leak into this run.
                        state    <= RUN;
                        x_reg    <= x;
                        acc      <= coef[LAST];
                        cnt      <= FIRST;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= full[DW-1:0];
                    if (step_ovf) overflow <= 1'b1;
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - AW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign result = acc;
    assign ready  = (state != RUN);
    assign valid  = (state == DONE);

endmodule

// File: tb/tb_horner_poly_solver.sv
// Directed bench for horner_poly_solver: a DEGREE=2 instance and a DEGREE=4/DW=24 instance.
module tb_horner_poly_solver;

    logic        clock;
    logic        reset;

    logic        start;
    logic [7:0]  x;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data;
    logic [15:0] result;
    logic        overflow, ready, valid;

    logic        start4;
    logic [7:0]  x4;
    logic        coef_we4;
    logic [2:0]  coef_addr4;
    logic [23:0] coef_data4;
    logic [23:0] result4;
    logic        overflow4, ready4, valid4;

    int tests_run = 0;
    int tests_failed = 0;

    horner_poly_solver dut (
        .clock(clock), .reset(reset), .start(start), .x(x),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .result(result), .overflow(overflow), .ready(ready), .valid(valid)
    );

    horner_poly_solver #(.XW(8), .DW(24), .DEGREE(4), .AW(3)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .x(x4),
        .coef_we(coef_we4), .coef_addr(coef_addr4), .coef_data(coef_data4),
        .result(result4), .overflow(overflow4), .ready(ready4), .valid(valid4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write2(input logic [2:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        step();
        coef_we = 1'b0;
    endtask

    task automatic start2(input logic [7:0] xv);
        start = 1'b1; x = xv;
        step();
        start = 1'b0;
    endtask

    // Returns the number of edges after the accepting edge until valid is seen.
    task automatic wait_valid2(input string tag, output int n);
        n = 0;
        while (!valid && n < 50) begin
            step();
            n++;
        end
        if (!valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic load2(input int c2, input int c1, input int c0);
        write2(3'd2, 16'(c2));
        write2(3'd1, 16'(c1));
        write2(3'd0, 16'(c0));
    endtask

    initial begin
        int n;
        int ready_lo;
        start = 0; x = 0; coef_we = 0; coef_addr = 0; coef_data = 0;
        start4 = 0; x4 = 0; coef_we4 = 0; coef_addr4 = 0; coef_data4 = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        check("rst_ready", ready, 1);
        check("rst_valid", valid, 0);
        check("rst_result", $signed(result), 0);
        check("rst_overflow", overflow, 0);

        // 3x^2 - 2x + 5 at x=4 -> 45, with latency and ready checks.
        load2(3, -2, 5);
        start2(8'sd4);
        ready_lo = 0;
        n = 0;
        while (!valid && n < 50) begin
            if (!ready) ready_lo++;
            step();
            n++;
        end
        check("lat_edges", n + 1, 3);
        check("run_ready_low", ready_lo, 2);
        check("basic_result", $signed(result), 45);
        check("basic_overflow", overflow, 0);

        // 2x^2 at x=-128: -256 then 32768 wraps to -32768.
        load2(2, 0, 0);
        start2(-8'sd128);
        wait_valid2("ovf", n);
        check("ovf_result", $signed(result), -32768);
        check("ovf_flag", overflow, 1);

        // New start clears the sticky flag.
        load2(3, -2, 5);
        start2(8'sd4);
        wait_valid2("clr", n);
        check("clr_result", $signed(result), 45);
        check("clr_overflow", overflow, 0);

        // Back-to-back from DONE with x=-1 -> 10; valid drops on the start edge.
        start2(-8'sd1);
        check("b2b_valid_drop", valid, 0);
        wait_valid2("b2b", n);
        check("b2b_result", $signed(result), 10);
        for (int i = 0; i < 20; i++) step();
        check("hold_valid", valid, 1);
        check("hold_result", $signed(result), 10);

        // Coefficient write and start during RUN are both ignored.
        start2(8'sd4);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd100;
        start = 1'b1; x = 8'sd7;
        step();
        coef_we = 1'b0; start = 1'b0;
        wait_valid2("run_ign", n);
        check("run_ignore_result", $signed(result), 45);
        write2(3'd5, 16'd77);
        start2(8'sd4);
        wait_valid2("run_ign2", n);
        check("run_ignore_again", $signed(result), 45);

        // Same-edge write of c2=7 and start x=1: this run uses old c2 -> 6; next run -> 10.
        coef_we = 1'b1; coef_addr = 3'd2; coef_data = 16'd7;
        start = 1'b1; x = 8'sd1;
        step();
        coef_we = 1'b0; start = 1'b0;
        wait_valid2("same", n);
        check("same_edge_old", $signed(result), 6);
        start2(8'sd1);
        wait_valid2("same2", n);
        check("same_edge_new", $signed(result), 10);

        // Reset on the second RUN cycle aborts and clears coefficients.
        start2(8'sd4);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_valid", valid, 0);
        check("abort_result", $signed(result), 0);
        start2(8'sd9);
        wait_valid2("zero", n);
        check("zero_coef_result", $signed(result), 0);

        // DEGREE=4, DW=24: x^4 - 1 at x=10 -> 9999.
        for (int i = 0; i <= 4; i++) begin
            coef_we4 = 1'b1; coef_addr4 = 3'(i);
            coef_data4 = (i == 4) ? 24'd1 : (i == 0) ? 24'hFFFFFF : 24'd0;
            step();
        end
        coef_we4 = 1'b0;
        start4 = 1'b1; x4 = 8'sd10;
        step();
        start4 = 1'b0;
        n = 0;
        while (!valid4 && n < 50) begin
            step();
            n++;
        end
        if (!valid4) check("d4_timeout", 0, 1);
        check("d4_lat_edges", n + 1, 5);
        check("d4_result", $signed(result4), 9999);
        check("d4_overflow", overflow4, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
